// File: rtl/conv_result_drain.sv
// Result frame buffer: captures (row, col, data) writes until a full OUT_DIM x OUT_DIM
// frame has landed, then replays it in raster order over a valid/ready stream.
module conv_result_drain #(
    parameter int DW      = 32,
    parameter int OUT_DIM = 24,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [4:0]    in_row,
    input  logic [4:0]    in_col,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_row,
    output logic [4:0]    out_col,
    output logic          out_last,
    output logic          busy,
    output logic          overflow,
    output logic          range_err
);
    localparam int N  = OUT_DIM * OUT_DIM;
    // One extra bit so the counters can hold N even when 2**AW == N.
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [DW-1:0]   mem [0:N-1];
    logic [CW-1:0]   wr_cnt_r;
    logic [CW-1:0]   rd_ptr_r;
    logic [4:0]      rd_row_r;
    logic [4:0]      rd_col_r;
    logic            out_valid_r;
    logic [DW-1:0]   out_data_r;
    logic [4:0]      out_row_r;
    logic [4:0]      out_col_r;
    logic            out_last_r;
    logic            overflow_r;
    logic            range_err_r;
    logic            in_range_s;
    logic            wr_en_s;
    logic            xfer_s;
    logic            last_xfer_s;
    logic            load_s;
    logic [AW-1:0]   wr_addr_s;

    // Write qualification, address math and output-stage handshake decode.
    always_comb begin
        in_range_s  = (in_row < 5'(OUT_DIM)) && (in_col < 5'(OUT_DIM));
        wr_addr_s   = AW'(in_row) * AW'(OUT_DIM) + AW'(in_col);
        wr_en_s     = in_valid && in_range_s && (state_r == FILL);
        xfer_s      = out_valid_r && out_ready;
        last_xfer_s = xfer_s && out_last_r;
        load_s      = (state_r == DRAIN) && !last_xfer_s &&
                      (!out_valid_r || out_ready) && (rd_ptr_r < CW'(N));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FILL: begin
                if (wr_en_s && (wr_cnt_r == CW'(N - 1))) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                if (last_xfer_s) begin
                    state_s = FILL;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= in_data;
        end
    end

    // Write counter, sticky error flags and the registered read/output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r    <= '0;
            rd_ptr_r    <= '0;
            rd_row_r    <= 5'd0;
            rd_col_r    <= 5'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_row_r   <= 5'd0;
            out_col_r   <= 5'd0;
            out_last_r  <= 1'b0;
            overflow_r  <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                if (wr_cnt_r == CW'(N - 1)) begin
                    wr_cnt_r <= '0;
                end else begin
                    wr_cnt_r <= wr_cnt_r + CW'(1);
                end
            end
            if (in_valid && (state_r == DRAIN)) begin
                overflow_r <= 1'b1;
            end
            if (in_valid && !in_range_s) begin
                range_err_r <= 1'b1;
            end
            // A beat is (re)loaded whenever the output slot is empty or being consumed.
            if (last_xfer_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                rd_ptr_r    <= '0;
                rd_row_r    <= 5'd0;
                rd_col_r    <= 5'd0;
            end else if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mem[rd_ptr_r[AW-1:0]];
                out_row_r   <= rd_row_r;
                out_col_r   <= rd_col_r;
                out_last_r  <= (rd_ptr_r == CW'(N - 1));
                rd_ptr_r    <= rd_ptr_r + CW'(1);
                if (rd_col_r == 5'(OUT_DIM - 1)) begin
                    rd_col_r <= 5'd0;
                    rd_row_r <= rd_row_r + 5'd1;
                end else begin
                    rd_col_r <= rd_col_r + 5'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_row   = out_row_r;
    assign out_col   = out_col_r;
    assign out_last  = out_last_r;
    assign busy      = (state_r == DRAIN);
    assign overflow  = overflow_r;
    assign range_err = range_err_r;

endmodule

// File: tb/tb_conv_result_drain.sv
// Self-checking bench for conv_result_drain: scenario table plus reset and back-to-back
// sequences, with a frame model feeding an expected-beat queue.
module tb_conv_result_drain;
    localparam int DW = 32;
    localparam int OD = 24;
    localparam int AW = 10;
    localparam int N  = OD * OD;

    typedef struct {
        logic [4:0]    row;
        logic [4:0]    col;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int         order;
        int         stall;
        int         base;
        bit         rng;
        bit         ovf;
        logic [1:0] exp_flags;
    } scen_t;

    logic          clk, rst, in_valid, out_ready, out_valid, out_last, busy, overflow, range_err;
    logic [4:0]    in_row, in_col, out_row, out_col;
    logic [DW-1:0] in_data, out_data;

    int            n_cmp, n_err;
    beat_t         sb[$];
    logic [DW-1:0] exp_mem [N];
    int            m_cnt, frame_beats, ready_mode;
    bit            m_drain, held_v, prev_xfer;
    logic [DW+11:0] held;
    int            perm [N];
    scen_t         tbl [4];

    conv_result_drain #(.DW(DW), .OUT_DIM(OD), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
        .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy),
        .overflow(overflow), .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        beat_t e;
        logic [DW+11:0] now;
        now = {out_valid, out_data, out_row, out_col, out_last};
        if (rst) begin
            held_v = 1'b0;
            prev_xfer = 1'b0;
            return;
        end
        if (held_v) cmp("hold_stable", 64'(now), 64'(held));
        if (prev_xfer && sb.size() > 0) cmp("no_bubble", 64'(out_valid), 64'(1));
        prev_xfer = 1'b0;
        if (out_valid && out_ready) begin
            held_v = 1'b0;
            if (sb.size() == 0) begin
                cmp("unexpected_beat", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                cmp("beat", 64'({out_row, out_col, out_data, out_last}),
                    64'({e.row, e.col, e.data, e.last}));
                frame_beats++;
                if (e.last) m_drain = 1'b0;
                else prev_xfer = 1'b1;
            end
        end else if (out_valid) begin
            held_v = 1'b1;
            held = now;
        end else begin
            held_v = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_write(int r, int c, logic [DW-1:0] d);
        beat_t b;
        in_valid = 1'b1;
        in_row = 5'(r);
        in_col = 5'(c);
        in_data = d;
        if (!m_drain && r < OD && c < OD) begin
            exp_mem[r*OD+c] = d;
            m_cnt++;
            if (m_cnt == N) begin
                m_cnt = 0;
                m_drain = 1'b1;
                frame_beats = 0;
                for (int k = 0; k < N; k++) begin
                    b.row = 5'(k / OD);
                    b.col = 5'(k % OD);
                    b.data = exp_mem[k];
                    b.last = (k == N - 1);
                    sb.push_back(b);
                end
            end
        end
    endtask

    task automatic fill(int order, int base, bit rng_inj, int nw);
        int t, j;
        for (int k = 0; k < N; k++) perm[k] = (order == 1) ? N - 1 - k : k;
        if (order == 2) begin
            for (int k = N - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
        end
        for (int k = 0; k < nw; k++) begin
            if (rng_inj && k == 10) begin
                drive_write(OD, 3, 32'hBAD0); cycle();
                drive_write(5, 31, 32'hBAD1); cycle();
                in_valid = 1'b0;
            end
            drive_write(perm[k] / OD, perm[k] % OD,
                        DW'(base + (perm[k] / OD) * 100 + perm[k] % OD));
            cycle();
            in_valid = 1'b0;
        end
        if (m_drain) begin
            cmp("lat_busy_novalid", 64'({busy, out_valid}), 64'(2'b10));
            cycle();
            cmp("lat_valid", 64'(out_valid), 64'(1));
        end
    endtask

    task automatic drain_wait(bit ovf_inj);
        for (int it = 0; it < 4000 && m_drain; it++) begin
            if (ovf_inj && (it % 5 == 2))
                drive_write(int'($urandom_range(0, OD-1)), int'($urandom_range(0, OD-1)), 32'hF00D);
            cycle();
            in_valid = 1'b0;
        end
        cmp("drain_done", 64'(m_drain), 64'(0));
        cmp("after_last", 64'({busy, out_valid}), 64'(2'b00));
    endtask

    task automatic run_reset();
        rst = 1'b1;
        #1;
        cmp("reset_outputs", 64'({out_valid, out_data, out_row, out_col, out_last, busy, overflow, range_err}), 64'(0));
        cycle();
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_drain = 1'b0;
        held_v = 1'b0;
        prev_xfer = 1'b0;
        frame_beats = 0;
    endtask

    initial begin
        tbl[0] = '{order: 0, stall: 0, base: 0,    rng: 1'b0, ovf: 1'b0, exp_flags: 2'b00};
        tbl[1] = '{order: 1, stall: 1, base: 1000, rng: 1'b0, ovf: 1'b0, exp_flags: 2'b00};
        tbl[2] = '{order: 2, stall: 1, base: 5000, rng: 1'b0, ovf: 1'b0, exp_flags: 2'b00};
        tbl[3] = '{order: 0, stall: 1, base: 3000, rng: 1'b1, ovf: 1'b1, exp_flags: 2'b11};
        n_cmp = 0; n_err = 0; m_cnt = 0; m_drain = 1'b0; held_v = 1'b0; prev_xfer = 1'b0;
        frame_beats = 0; ready_mode = 0;
        rst = 1'b1; in_valid = 1'b0; in_row = 5'd0; in_col = 5'd0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", 64'({out_valid, out_data, out_row, out_col, out_last, busy, overflow, range_err}), 64'(0));
        rst = 1'b0;
        cycle();

        for (int s = 0; s < 4; s++) begin
            ready_mode = tbl[s].stall;
            cmp("busy_in_fill", 64'(busy), 64'(0));
            fill(tbl[s].order, tbl[s].base, tbl[s].rng, N);
            drain_wait(tbl[s].ovf);
            cmp("sticky_flags", 64'({overflow, range_err}), 64'(tbl[s].exp_flags));
        end

        // Back-to-back frames: second frame's writes start the cycle after out_last.
        ready_mode = 0;
        fill(0, 7000, 1'b0, N);
        drain_wait(1'b0);
        fill(1, 9000, 1'b0, N);
        drain_wait(1'b0);

        // Reset mid-fill, then a clean frame.
        fill(2, 11000, 1'b0, 300);
        run_reset();
        fill(0, 13000, 1'b0, N);
        drain_wait(1'b0);

        // Reset at beat 100 of a drain, then a clean frame.
        ready_mode = 1;
        fill(1, 15000, 1'b0, N);
        for (int it = 0; it < 4000 && frame_beats < 100; it++) cycle();
        cmp("beat100_reached", 64'(frame_beats), 64'(100));
        run_reset();
        fill(0, 17000, 1'b0, N);
        drain_wait(1'b0);
        cmp("flags_after_reset", 64'({overflow, range_err}), 64'(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
